// File: rtl/can_pkg.sv
// Shared CAN line constants used by the stuffing transmitter
// and the receive-side destuffer.
package can_pkg;

    localparam logic CAN_RECESSIVE = 1'b1;
    localparam int   CAN_STUFF_LEN = 5;

endpackage

// File: rtl/can_stuff_run.sv
// Run-length tracker for bit stuffing: counts identical bits
// and raises stuff_req once a run reaches STUFF_LEN.
module can_stuff_run
    import can_pkg::*;
#(
    parameter int STUFF_LEN = CAN_STUFF_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_valid,
    input  logic bit_val,
    input  logic is_stuff,
    input  logic clear,
    output logic stuff_req,
    output logic stuff_val
);

    localparam logic [2:0] LEN = 3'(STUFF_LEN);

    logic [2:0] run_cnt;
    logic [2:0] run_nxt;
    logic       last_bit;
    logic       stuff_pend;

    always_comb begin
        run_nxt = 3'd1;
        if (bit_val == last_bit)
            run_nxt = (run_cnt == LEN) ? LEN : run_cnt + 3'd1;
    end

    // clear wins over a same-cycle bit so a frame start discards history
    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            run_cnt    <= 3'd0;
            last_bit   <= CAN_RECESSIVE;
            stuff_pend <= 1'b0;
        end else if (bit_valid) begin
            if (is_stuff) begin
                run_cnt    <= 3'd1;
                last_bit   <= bit_val;
                stuff_pend <= 1'b0;
            end else begin
                run_cnt    <= run_nxt;
                last_bit   <= bit_val;
                stuff_pend <= (run_nxt == LEN);
            end
        end
    end

    assign stuff_req = stuff_pend;
    assign stuff_val = ~last_bit;

endmodule

// File: rtl/can_stuff_tx.sv
// MSB-first CAN serializer with bit stuffing; stuffing is built
// only when CAN_TX_STUFF_EN is defined, else a plain serializer.
module can_stuff_tx
    import can_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int STUFF_LEN = CAN_STUFF_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              frame_start,
    input  logic              bit_en,
    output logic              ready,
    output logic              dout,
    output logic              stuff_bit,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh;
    logic [CW-1:0]     bit_cnt;
    logic              stuff_pend;
    logic              accept;
    logic              emit_data;
    logic              emit_stuff;
    logic              nxt_bit;

    assign ready  = (bit_cnt == '0);
    assign accept = load && ready;

`ifdef CAN_TX_STUFF_EN
    logic stuff_val;
    logic stuff_q;
    logic emit_idle;

    assign emit_stuff = bit_en && stuff_pend;
    assign emit_data  = bit_en && !stuff_pend && !ready;
    assign emit_idle  = bit_en && !stuff_pend && ready;

    can_stuff_run #(
        .STUFF_LEN (STUFF_LEN)
    ) u_run (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_valid (emit_stuff || emit_data),
        .bit_val   (nxt_bit),
        .is_stuff  (stuff_pend),
        .clear     (emit_idle || (accept && frame_start)),
        .stuff_req (stuff_pend),
        .stuff_val (stuff_val)
    );

    always_comb begin
        nxt_bit = CAN_RECESSIVE;
        if (emit_stuff)
            nxt_bit = stuff_val;
        else if (emit_data)
            nxt_bit = sh[DATA_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst_n)
            stuff_q <= 1'b0;
        else if (bit_en)
            stuff_q <= emit_stuff;
    end

    assign stuff_bit = stuff_q;
`else
    logic unused_cfg;

    assign stuff_pend = 1'b0;
    assign emit_stuff = 1'b0;
    assign emit_data  = bit_en && !ready;
    assign nxt_bit    = emit_data ? sh[DATA_W-1] : CAN_RECESSIVE;
    assign stuff_bit  = emit_stuff;
    assign unused_cfg = frame_start ^ (STUFF_LEN > 7);
`endif

    assign busy = !ready || stuff_pend;

    // a load can only coincide with a stuff or idle slot, never a data shift
    always_ff @(posedge clk) begin
        if (rst_n) begin
            dout    <= CAN_RECESSIVE;
            sh      <= '0;
            bit_cnt <= '0;
        end else begin
            if (bit_en)
                dout <= nxt_bit;
            if (emit_data) begin
                sh      <= sh << 1;
                bit_cnt <= bit_cnt - CW'(1);
            end
            if (accept) begin
                sh      <= data_in;
                bit_cnt <= CW'(DATA_W);
            end
        end
    end

endmodule

// File: doc/can_stuff_tx.md
# can_stuff_tx

Bit-stuffing serial transmitter for the CAN controller datapath. It accepts one data byte at a time over a load/ready handshake and shifts it out MSB-first on a single serial line, paced by a bit-time strobe. After every run of STUFF_LEN identical bits it inserts one complementary stuff bit. It is the transmit-side counterpart of the serial sequence detector / destuffer: that block consumes `din` and flags bit runs, while this block generates the stream.

## Interface
- `DATA_W`, default 8: byte width loaded per handshake.
- `STUFF_LEN`, default 5: run length that triggers a stuff bit. Legal range is 2..7.

- `clk`  in  1  sole clock. All state updates on the rising edge.
- `rst_n`  in  1  reset. Synchronous and active-high despite the name: 1 = reset, 0 = run.
- `load`  in  1  byte-valid strobe; the byte is accepted when `load && ready` on a rising edge.
- `data_in`  in  DATA_W  byte to transmit; sampled on acceptance.
- `frame_start`  in  1  qualifies `load`. When set on acceptance, it clears run history and any pending stuff bit.
- `bit_en`  in  1  one-cycle bit-time strobe. At most one bit is emitted per strobe.
- `ready`  out  1  shift register empty; a byte can be accepted.
- `dout`  out  1  registered serial output; idle level is recessive 1.
- `stuff_bit`  out  1  high while the current `dout` value is a stuff bit.
- `busy`  out  1  data bits remain or a stuff bit is pending.

## Operation
- Reset values: `dout`=1, `ready`=1, `busy`=0, `stuff_bit`=0. Internal state resets to run_cnt=0, last_bit=1, stuff_pend=0, bit_cnt=0.
- Priority on each `bit_en`:
  - If stuff_pend=1: emit ~last_bit with `stuff_bit`=1. Then last_bit flips, run_cnt=1, stuff_pend=0. The stuff bit counts toward the next run.
  - Else if bit_cnt>0: emit the shift MSB with `stuff_bit`=0, shift left, and decrement bit_cnt. If the bit equals last_bit, run_cnt++; otherwise run_cnt=1. Set last_bit to the bit. If run_cnt reaches STUFF_LEN, set stuff_pend.
  - Else (idle): emit 1, run_cnt=0, last_bit=1.
- No `bit_en`: `dout` and `stuff_bit` hold.
- A pending stuff bit after a byte's last bit is sent before the next byte's first bit, even across a new load without `frame_start`.
- Run history carries across bytes unless `frame_start` is set on the load.
- `ready` = (bit_cnt==0). `busy` = (bit_cnt!=0) || stuff_pend.
- `load` while `ready`=0 is ignored; no queuing.
- run_cnt is 3 bits wide and saturates at STUFF_LEN.

## Timing
- Accepted `load` at edge N: `ready`=0 after edge N. The first data bit appears on `dout` at the first `bit_en` edge after N.
- `load` and `bit_en` in the same cycle: `bit_en` acts on the pre-load state (stuff bit or idle bit), then the byte loads.
- `ready` rises on the edge that emits the last data bit. Back-to-back bytes lose no bit slot if `load` arrives before the next `bit_en`.
- Stuffed byte latency is DATA_W plus the number of stuff bits, in `bit_en` strobes.
- `rst_n` mid-byte: all outputs return to reset values on that edge, and the partial byte is discarded.

## Configuration
- `CAN_TX_STUFF_EN` defined: stuffing behaves as described above.
- `CAN_TX_STUFF_EN` undefined: the block is a plain serializer. No stuff bits are emitted, `stuff_bit` is tied to 0, stuff_pend and run tracking are removed, and `busy` = (bit_cnt!=0).

## Structure
- Shared package `can_pkg` holds `CAN_RECESSIVE` = 1'b1 and the default `CAN_STUFF_LEN` = 5. The destuffer on the receive side uses the same constants.
- One sub-module, `can_stuff_run`: run counter plus last_bit and stuff_pend logic. It exposes `stuff_req` and takes `bit_valid`, `bit_val`, `is_stuff` and `clear`. It is instantiated only under `CAN_TX_STUFF_EN`.

## Test plan
- Reset with `bit_en` every cycle -> `dout`=1, `ready`=1, `busy`=0 for 10 cycles.
- Load 0x00 with `frame_start`, `bit_en` every cycle -> `dout` = 0,0,0,0,0,1(`stuff_bit`=1),0,0,0; `ready` rises after the 9th strobe.
- Load 0xAA with `frame_start` -> 1,0,1,0,1,0,1,0 with no stuff bits; exactly 8 strobes.
- Load 0xF8 with `frame_start`, then 0x3F back-to-back without `frame_start` -> first byte 1,1,1,1,1,[0],0,0,0; second byte 0,[1],0,1,1,1,1,1,[0],1 (brackets mark stuff bits).
- Load 0x00, then assert `rst_n` after 3 bits -> outputs return to reset values on that edge; a new 0xAA load then transmits cleanly.
- With `CAN_TX_STUFF_EN` undefined, load 0x00 -> eight 0s in 8 strobes, `stuff_bit` always 0.
